// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: masked stall merge plus multi-cycle exception flush sequencing.
// Optional stall watchdog is built when STALL_WATCHDOG_EN is defined.
module pipe_ctrl_gen #(
    parameter int unsigned              NSTAGE       = 6,
    parameter int unsigned              NREQ         = 4,
    parameter logic [NREQ*NSTAGE-1:0]   STALL_MASKS  = {6'b011110, 6'b001110, 6'b000110, 6'b000010},
    parameter logic [31:0]              VEC_BASE     = 32'hBFC0_0380,
    parameter logic [31:0]              ERET_CODE    = 32'h0000_000E,
    parameter int unsigned              FLUSH_CYCLES = 1,
    parameter int unsigned              WD_LIMIT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              new_pc_valid,
    output logic              busy_flush,
    output logic              stall_timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       pc_q, pc_d;

    logic [NSTAGE-1:0] stall_merge;
    logic [NSTAGE-1:0] stall_c;
    logic              flush_c;
    logic [31:0]       pc_c;
    logic              valid_c;
    logic              busy_c;

    always_comb begin
        stall_merge = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (stallreq_i[i]) begin
                stall_merge = stall_merge | STALL_MASKS[i*NSTAGE +: NSTAGE];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        stall_c = '0;
        flush_c = 1'b0;
        pc_c    = '0;
        valid_c = 1'b0;
        busy_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (excepttype_i != 32'd0) begin
                    flush_c = 1'b1;
                    valid_c = 1'b1;
                    pc_c    = (excepttype_i == ERET_CODE) ? cp0_epc_i : VEC_BASE;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_INIT;
                        pc_d    = pc_c;
                    end
                end else begin
                    stall_c = stall_merge;
                end
            end
            ST_FLUSH: begin
                // Inputs are ignored here; the redirect target was captured on accept.
                flush_c = 1'b1;
                busy_c  = 1'b1;
                pc_c    = pc_q;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign stall        = rst ? stall_c : '0;
    assign flush        = rst & flush_c;
    assign new_pc       = rst ? pc_c : 32'd0;
    assign new_pc_valid = rst & valid_c;
    assign busy_flush   = rst & busy_c;

`ifdef STALL_WATCHDOG_EN
    localparam logic [15:0] WD_LIM = WD_LIMIT[15:0];

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d = '0;
        if ((stall_c != '0) && !flush_c) begin
            wd_cnt_d = (wd_cnt_q >= WD_LIM) ? WD_LIM : wd_cnt_q + 16'd1;
        end
        timeout_d = timeout_q | (wd_cnt_q == WD_LIM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;
`else
    logic unused_wd;
    assign unused_wd     = ^WD_LIMIT;
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: two instances (FLUSH_CYCLES=1 and 3) share stimulus;
// expected outputs are queued by the driver and checked by an independent monitor.
module tb_pipe_ctrl_gen;

`ifdef STALL_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif
    localparam logic [31:0] VB  = 32'hBFC0_0380;
    localparam logic [31:0] EPC = 32'h8000_1234;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  stallreq_i = '0;
    logic [31:0] excepttype_i = '0;
    logic [31:0] cp0_epc_i = '0;

    logic [5:0]  stall1, stall3;
    logic        flush1, flush3, valid1, valid3, busy1, busy3, to1, to3;
    logic [31:0] pc1, pc3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [5:0]  s1;
        logic        f1;
        logic [31:0] p1;
        logic        v1;
        logic        b1;
        logic [5:0]  s3;
        logic        f3;
        logic [31:0] p3;
        logic        v3;
        logic        b3;
        logic        to;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl_gen #(.FLUSH_CYCLES(1), .WD_LIMIT(8)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .stallreq_i    (stallreq_i),
        .excepttype_i  (excepttype_i),
        .cp0_epc_i     (cp0_epc_i),
        .stall         (stall1),
        .flush         (flush1),
        .new_pc        (pc1),
        .new_pc_valid  (valid1),
        .busy_flush    (busy1),
        .stall_timeout (to1)
    );

    pipe_ctrl_gen #(.FLUSH_CYCLES(3), .WD_LIMIT(8)) u_dut3 (
        .clk           (clk),
        .rst           (rst),
        .stallreq_i    (stallreq_i),
        .excepttype_i  (excepttype_i),
        .cp0_epc_i     (cp0_epc_i),
        .stall         (stall3),
        .flush         (flush3),
        .new_pc        (pc3),
        .new_pc_valid  (valid3),
        .busy_flush    (busy3),
        .stall_timeout (to3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle carrying a queued expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".stall1"}, 32'(stall1), 32'(e.s1));
            chk({e.name, ".flush1"}, 32'(flush1), 32'(e.f1));
            chk({e.name, ".pc1"},    pc1,         e.p1);
            chk({e.name, ".valid1"}, 32'(valid1), 32'(e.v1));
            chk({e.name, ".busy1"},  32'(busy1),  32'(e.b1));
            chk({e.name, ".stall3"}, 32'(stall3), 32'(e.s3));
            chk({e.name, ".flush3"}, 32'(flush3), 32'(e.f3));
            chk({e.name, ".pc3"},    pc3,         e.p3);
            chk({e.name, ".valid3"}, 32'(valid3), 32'(e.v3));
            chk({e.name, ".busy3"},  32'(busy3),  32'(e.b3));
            chk({e.name, ".to1"},    32'(to1),    32'(e.to));
            chk({e.name, ".to3"},    32'(to3),    32'(e.to));
        end
    end

    task automatic step(input string name, input logic r, input logic [3:0] req,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input logic [5:0] s1, input logic f1, input logic [31:0] p1,
                        input logic v1, input logic b1,
                        input logic [5:0] s3, input logic f3, input logic [31:0] p3,
                        input logic v3, input logic b3, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_i   = req;
        excepttype_i = exc;
        cp0_epc_i    = epc;
        e = '{name, s1, f1, p1, v1, b1, s3, f3, p3, v3, b3, to};
        sb.push_back(e);
    endtask

    // Both instances expected to behave identically (neither in FLUSH).
    task automatic both(input string name, input logic r, input logic [3:0] req,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input logic [5:0] s, input logic f, input logic [31:0] p,
                        input logic v, input logic to);
        step(name, r, req, exc, epc, s, f, p, v, 1'b0, s, f, p, v, 1'b0, to);
    endtask

    initial begin
        both("reset_held", 1'b0, 4'b1111, 32'h8, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        both("req_0001", 1'b1, 4'b0001, 32'h0, 32'h0, 6'b000010, 1'b0, 32'h0, 1'b0, 1'b0);
        both("req_1010", 1'b1, 4'b1010, 32'h0, 32'h0, 6'b011110, 1'b0, 32'h0, 1'b0, 1'b0);
        both("req_0110", 1'b1, 4'b0110, 32'h0, 32'h0, 6'b001110, 1'b0, 32'h0, 1'b0, 1'b0);
        both("req_0000", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        both("exc8_stall", 1'b1, 4'b1111, 32'h8, 32'h0, 6'b0, 1'b1, VB, 1'b1, 1'b0);
        step("after_exc8", 1'b1, 4'b1111, 32'h0, 32'h0,
             6'b011110, 1'b0, 32'h0, 1'b0, 1'b0, 6'b0, 1'b1, VB, 1'b0, 1'b1, 1'b0);
        step("flush3_c2", 1'b1, 4'b0000, 32'h0, 32'h0,
             6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 6'b0, 1'b1, VB, 1'b0, 1'b1, 1'b0);
        both("idle_again", 1'b1, 4'b0001, 32'h0, 32'h0, 6'b000010, 1'b0, 32'h0, 1'b0, 1'b0);
        both("eret", 1'b1, 4'b0000, 32'hE, EPC, 6'b0, 1'b1, EPC, 1'b1, 1'b0);
        step("second_exc", 1'b1, 4'b0000, 32'h8, EPC,
             6'b0, 1'b1, VB, 1'b1, 1'b0, 6'b0, 1'b1, EPC, 1'b0, 1'b1, 1'b0);
        step("unknown_in_flush", 1'b1, 4'b0011, 32'h1F, EPC,
             6'b0, 1'b1, VB, 1'b1, 1'b0, 6'b0, 1'b1, EPC, 1'b0, 1'b1, 1'b0);
        both("pending_accept", 1'b1, 4'b0000, 32'h1F, EPC, 6'b0, 1'b1, VB, 1'b1, 1'b0);
        step("flush_mid", 1'b1, 4'b0000, 32'h0, 32'h0,
             6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 6'b0, 1'b1, VB, 1'b0, 1'b1, 1'b0);
        both("rst_mid_flush", 1'b0, 4'b1111, 32'h8, EPC, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        both("post_rst", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++)
            both("wd_a", 1'b1, 4'b0001, 32'h0, 32'h0, 6'b000010, 1'b0, 32'h0, 1'b0, 1'b0);
        both("wd_gap", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            both("wd_b", 1'b1, 4'b0001, 32'h0, 32'h0, 6'b000010, 1'b0, 32'h0, 1'b0, 1'b0);
        both("wd_gap2", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            both("wd_c", 1'b1, 4'b0100, 32'h0, 32'h0, 6'b001110, 1'b0, 32'h0, 1'b0, 1'b0);
        both("wd_reach", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            both("wd_sticky", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, WD_ON);
        both("wd_sticky_stall", 1'b1, 4'b1000, 32'h0, 32'h0, 6'b011110, 1'b0, 32'h0, 1'b0, WD_ON);
        both("wd_rst", 1'b0, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        both("wd_after_rst", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
